// File: rtl/stage_read.sv
// rtl/stage_read.sv - operand-read stage: 8-entry register file, LOADC immediate, load-use stall.
// Optional macro RF_BYPASS_EN: write-back data is forwarded to same-cycle operand reads.
module stage_read #(
  parameter int         DATA_W    = 32,
  parameter logic [6:0] NOP_OPC   = 7'h00,
  parameter logic [6:0] LOAD_OPC  = 7'h01,
  parameter logic [6:0] LOADC_OPC = 7'h02,
  parameter logic [6:0] JMPC_OPC  = 7'h04
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [2:0]        wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] data_1_o,
  output logic [DATA_W-1:0] data_2_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        dest_o
);

  logic [DATA_W-1:0] r_rf [8];
  logic              r_ld_valid;
  logic [2:0]        r_ld_dest;

  logic [6:0]        w_opc;
  logic [2:0]        w_dest;
  logic [2:0]        w_src1;
  logic [2:0]        w_src2;
  logic [7:0]        w_imm;
  logic              w_is_loadc;
  logic [2:0]        w_rd1_idx;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_use_a;
  logic              w_use_b;
  logic              w_hazard;
  logic              w_issue;
  logic [DATA_W-1:0] w_data_1;
  logic [DATA_W-1:0] w_data_2;

  assign w_opc      = instr_i[15:9];
  assign w_dest     = instr_i[8:6];
  assign w_src1     = instr_i[5:3];
  assign w_src2     = instr_i[2:0];
  assign w_imm      = instr_i[7:0];
  assign w_is_loadc = (w_opc == LOADC_OPC);
  // LOADC reads its own destination register in the first operand slot
  assign w_rd1_idx  = w_is_loadc ? w_dest : w_src1;

`ifdef RF_BYPASS_EN
  assign w_rd1 = (wb_en_i && (wb_dest_i == w_rd1_idx)) ? wb_data_i : r_rf[w_rd1_idx];
  assign w_rd2 = (wb_en_i && (wb_dest_i == w_src2))    ? wb_data_i : r_rf[w_src2];
`else
  assign w_rd1 = r_rf[w_rd1_idx];
  assign w_rd2 = r_rf[w_src2];
`endif

  always_comb begin
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    if (w_opc == NOP_OPC) begin
      w_use_a = 1'b0;
      w_use_b = 1'b0;
    end else if (w_is_loadc) begin
      w_use_a = 1'b1;
    end else begin
      w_use_a = 1'b1;
      w_use_b = 1'b1;
    end
  end

  assign w_hazard = instr_valid_i && r_ld_valid &&
                    ((w_use_a && (r_ld_dest == w_rd1_idx)) ||
                     (w_use_b && (r_ld_dest == w_src2)));
  assign stall_o  = w_hazard && !flush_i;
  assign w_issue  = !flush_i && instr_valid_i && !w_hazard;

  assign w_data_1 = w_rd1;
  assign w_data_2 = w_is_loadc ? {{(DATA_W-8){1'b0}}, w_imm} : w_rd2;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (wb_en_i) begin
      r_rf[wb_dest_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_1_o   <= '0;
      data_2_o   <= '0;
      opcode_o   <= NOP_OPC;
      dest_o     <= 3'd0;
      r_ld_valid <= 1'b0;
      r_ld_dest  <= 3'd0;
    end else if (w_issue) begin
      data_1_o   <= w_data_1;
      data_2_o   <= w_data_2;
      opcode_o   <= w_opc;
      dest_o     <= w_dest;
      r_ld_valid <= (w_opc == LOAD_OPC);
      r_ld_dest  <= w_dest;
    end else begin
      // flush, idle slot and hazard all issue the same bubble and forget the last load
      data_1_o   <= '0;
      data_2_o   <= '0;
      opcode_o   <= NOP_OPC;
      dest_o     <= 3'd0;
      r_ld_valid <= 1'b0;
      r_ld_dest  <= 3'd0;
    end
  end

endmodule
